alu_mac_accumulator: RTL and testbench

//  Downstream stage of the 4x4 ALU multiplier: consumes its 8-bit products as a

---
 rtl/alu_mac_accumulator.sv | 121 ++++++++++++
 tb/tb_alu_mac_accumulator.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mac_accumulator.sv
// ---------------------------------------------------------------------------
// alu_mac_accumulator
//   Sums a group of unsigned product terms (from the 4x4 ALU multiplier) into
//   one ACC_W-bit accumulator. It then presents {sum, term count, overflow} and
//   holds them until a consumer handshake.
//
//   Ports
//     clk, rst_n           rising-edge clock, async active-low reset
//     clear                synchronous abort of the current group / result
//     in_valid/in_ready    term stream handshake (in_ready is combinational)
//     in_prod, in_last     term value and group-close marker
//     out_valid/out_ready  result handshake
//     out_sum, out_count   group sum and number of terms (0 when !out_valid)
//     overflow             an add of this group exceeded 2^ACC_W-1
//
//   Configuration macro: ALU_MAC_SAT_EN
//     defined   -> the accumulator saturates at 2^ACC_W-1 on overflow
//     undefined -> the accumulator wraps mod 2^ACC_W on overflow
// ---------------------------------------------------------------------------
module alu_mac_accumulator #(
    parameter int PROD_W  = 8,
    parameter int ACC_W   = 16,
    parameter int N_TERMS = 4,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              overflow
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             accept;
    logic             final_term;
    logic [CNT_W-1:0] cnt_inc;
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] acc_next;

    // clear blocks acceptance in the same cycle so an aborted term never lands
    assign in_ready = !clear && (state != ST_DONE);
    assign accept   = in_valid && in_ready;

    assign cnt_inc    = cnt + CNT_W'(1);
    // Reaching N_TERMS closes the group regardless of in_last
    assign final_term = in_last || (cnt_inc == CNT_W'(N_TERMS));

    // One extra bit catches the carry out of the ACC_W-bit add
    assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    assign carry   = sum_ext[ACC_W];

`ifdef ALU_MAC_SAT_EN
    // Once saturated at all-ones, any nonzero term carries again, so the
    // value stays pinned for the rest of the group
    assign acc_next = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_next = sum_ext[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ACC: begin
                    if (accept) begin
                        acc   <= acc_next;
                        cnt   <= cnt_inc;
                        ovf   <= ovf | carry;
                        state <= final_term ? ST_DONE : ST_ACC;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    acc   <= '0;
                    cnt   <= '0;
                    ovf   <= 1'b0;
                end
            endcase
        end
    end

    // Result fields are registered state gated by out_valid: no in->out path
    assign out_valid = (state == ST_DONE);
    assign out_sum   = out_valid ? acc : '0;
    assign out_count = out_valid ? cnt : '0;
    assign overflow  = out_valid ? ovf : 1'b0;

endmodule

// File: tb/tb_alu_mac_accumulator.sv
module tb_alu_mac_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] clear = '0;
    logic [1:0] in_valid = '0;
    logic [1:0] in_last = '0;
    logic [1:0] out_ready = '0;
    logic [7:0] in_prod [2];
    logic [1:0] in_ready;
    logic [1:0] out_valid;
    logic [1:0] overflow;
    logic [15:0] sum_a;
    logic [9:0]  sum_b;
    logic [3:0]  cnt_a, cnt_b;
    logic [15:0] sum_v [2];
    logic [3:0]  cnt_v [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign sum_v[0] = sum_a;
    assign sum_v[1] = {6'b0, sum_b};
    assign cnt_v[0] = cnt_a;
    assign cnt_v[1] = cnt_b;

    // Instance 0: default parameters. Instance 1: narrow accumulator, 8 terms.
    alu_mac_accumulator #(.PROD_W(8), .ACC_W(16), .N_TERMS(4), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_prod(in_prod[0]),
        .in_last(in_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(sum_a), .out_count(cnt_a), .overflow(overflow[0])
    );

    alu_mac_accumulator #(.PROD_W(8), .ACC_W(10), .N_TERMS(8), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_prod(in_prod[1]),
        .in_last(in_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(sum_b), .out_count(cnt_b), .overflow(overflow[1])
    );

    // Reference: the group result from the plain arithmetic total of its terms
    function automatic int ref_sum(int d, int total);
        int w = (d == 1) ? 10 : 16;
        int max = (1 << w) - 1;
`ifdef ALU_MAC_SAT_EN
        return (total > max) ? max : total;
`else
        return total % (1 << w);
`endif
    endfunction

    function automatic bit ref_ovf(int d, int total);
        int w = (d == 1) ? 10 : 16;
        return total > ((1 << w) - 1);
    endfunction

    function automatic int n_terms(int d);
        return (d == 1) ? 8 : 4;
    endfunction

    // Called at a negedge: presents one term, checks it is acceptable, and
    // returns at the next negedge (term taken on the posedge in between).
    task automatic send_term(int d, int prod, bit last, string tag);
        in_valid[d] = 1'b1;
        in_prod[d]  = 8'(prod);
        in_last[d]  = last;
        #1;
        checks++;
        if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s send: in_ready=%0b out_valid=%0b, want 1/0", tag, in_ready[d], out_valid[d]);
        end
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_last[d]  = 1'b0;
    endtask

    // Called at the negedge right after the final term was taken.
    // Holds out_ready low for `stall` cycles while pushing junk terms.
    task automatic check_result(int d, int es, int ec, bit eo, int stall, string tag);
        for (int k = 0; k <= stall; k++) begin
            out_ready[d] = (k == stall);
            in_valid[d]  = (k < stall);
            in_prod[d]   = 8'($urandom_range(1, 255));
            #1;
            checks++;
            if (out_valid[d] !== 1'b1) begin
                errors++;
                $display("FAIL %s out_valid cyc%0d: got %0b want 1", tag, k, out_valid[d]);
            end
            checks++;
            if (sum_v[d] !== 16'(es)) begin
                errors++;
                $display("FAIL %s out_sum cyc%0d: got %0d want %0d", tag, k, sum_v[d], es);
            end
            checks++;
            if (cnt_v[d] !== 4'(ec)) begin
                errors++;
                $display("FAIL %s out_count cyc%0d: got %0d want %0d", tag, k, cnt_v[d], ec);
            end
            checks++;
            if (overflow[d] !== eo) begin
                errors++;
                $display("FAIL %s overflow cyc%0d: got %0b want %0b", tag, k, overflow[d], eo);
            end
            checks++;
            if (in_ready[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s in_ready in DONE cyc%0d: got %0b want 0", tag, k, in_ready[d]);
            end
            @(negedge clk);
        end
        out_ready[d] = 1'b0;
        in_valid[d]  = 1'b0;
        #1;
        checks++;
        if (out_valid[d] !== 1'b0 || sum_v[d] !== 16'd0 || in_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s after handshake: out_valid=%0b out_sum=%0d in_ready=%0b, want 0/0/1",
                     tag, out_valid[d], sum_v[d], in_ready[d]);
        end
    endtask

    task automatic check_zero(string tag);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (out_valid[d] !== 1'b0 || sum_v[d] !== 16'd0 || cnt_v[d] !== 4'd0 || overflow[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s dut%0d: out_valid=%0b sum=%0d count=%0d ovf=%0b, want all 0",
                         tag, d, out_valid[d], sum_v[d], cnt_v[d], overflow[d]);
            end
        end
    endtask

    task automatic test_reset();
        in_prod[0] = '0;
        in_prod[1] = '0;
        rst_n = 1'b0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (in_ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset in_ready dut%0d: got %0b want 1", d, in_ready[d]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_auto_close();
        for (int i = 0; i < 4; i++) send_term(0, 225, 1'b0, "auto_close");
        check_result(0, 900, 4, 1'b0, 0, "auto_close");
        @(negedge clk);
    endtask

    task automatic test_in_last();
        send_term(0, 6, 1'b0, "in_last");
        send_term(0, 10, 1'b1, "in_last");
        check_result(0, 16, 2, 1'b0, 0, "in_last");
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        send_term(0, 1, 1'b0, "stall");
        send_term(0, 2, 1'b0, "stall");
        send_term(0, 3, 1'b1, "stall");
        check_result(0, 6, 3, 1'b0, 5, "stall");
        // Junk pushed while stalled must not have leaked into this group
        send_term(0, 9, 1'b1, "after_stall");
        check_result(0, 9, 1, 1'b0, 0, "after_stall");
        @(negedge clk);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) send_term(1, 225, (i == 4), "overflow");
        check_result(1, ref_sum(1, 1125), 5, 1'b1, 0, "overflow");
        @(negedge clk);
    endtask

    task automatic test_clear();
        send_term(0, 50, 1'b0, "clear");
        send_term(0, 50, 1'b0, "clear");
        clear[0]    = 1'b1;
        in_valid[0] = 1'b1;
        in_prod[0]  = 8'd99;
        in_last[0]  = 1'b1;
        #1;
        checks++;
        if (in_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL clear in_ready: got %0b want 0", in_ready[0]);
        end
        @(negedge clk);
        clear[0]    = 1'b0;
        in_valid[0] = 1'b0;
        in_last[0]  = 1'b0;
        #1;
        checks++;
        if (out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL clear out_valid: got %0b want 0", out_valid[0]);
        end
        @(negedge clk);
        send_term(0, 7, 1'b1, "clear_next");
        check_result(0, 7, 1, 1'b0, 0, "clear_next");
        // clear also discards a pending result
        send_term(0, 4, 1'b1, "clear_done");
        clear[0] = 1'b1;
        @(negedge clk);
        clear[0] = 1'b0;
        #1;
        checks++;
        if (out_valid[0] !== 1'b0 || sum_a !== 16'd0) begin
            errors++;
            $display("FAIL clear_done: out_valid=%0b sum=%0d want 0/0", out_valid[0], sum_a);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        send_term(0, 100, 1'b0, "rst_mid");
        send_term(0, 100, 1'b0, "rst_mid");
        #2 rst_n = 1'b0;
        #1 check_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        send_term(0, 3, 1'b0, "rst_mid_next");
        send_term(0, 4, 1'b1, "rst_mid_next");
        check_result(0, 7, 2, 1'b0, 0, "rst_mid_next");
        @(negedge clk);
        for (int i = 0; i < 5; i++) send_term(1, 225, (i == 4), "rst_done");
        #2 rst_n = 1'b0;
        #1 check_zero("rst_done");
        @(negedge clk);
        rst_n = 1'b1;
        send_term(1, 5, 1'b1, "rst_done_next");
        check_result(1, 5, 1, 1'b0, 0, "rst_done_next");
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int d = 0; d < 2; d++) begin
            for (int g = 0; g < 15; g++) begin
                int len   = $urandom_range(1, n_terms(d));
                int total = 0;
                for (int i = 0; i < len; i++) begin
                    int p = $urandom_range(0, 225);
                    bit last;
                    repeat ($urandom_range(0, 1)) @(negedge clk);
                    if (i < len - 1) last = 1'b0;
                    else if (len < n_terms(d)) last = 1'b1;
                    else last = 1'($urandom_range(0, 1));
                    total += p;
                    send_term(d, p, last, "random");
                end
                check_result(d, ref_sum(d, total), len, ref_ovf(d, total),
                             $urandom_range(0, 3), "random");
                if ($urandom_range(0, 1) == 1) @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_auto_close();
        test_in_last();
        test_backpressure();
        test_overflow();
        test_clear();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
